// File: rtl/lc3_pkg.sv
// lc3_pkg
//   Shared LC-3 definitions for the execute path: opcode constants, the
//   ALU control encoding and the operate-sequencer state type.
//   No ports (package).
package lc3_pkg;

  localparam logic [3:0] OP_ADD = 4'b0001;
  localparam logic [3:0] OP_AND = 4'b0101;
  localparam logic [3:0] OP_NOT = 4'b1001;

  typedef enum logic [1:0] {
    ALU_PASS = 2'b00,
    ALU_ADD  = 2'b01,
    ALU_AND  = 2'b10,
    ALU_NOT  = 2'b11
  } aluCtrl_t;

  typedef enum logic [1:0] {
    S_IDLE   = 2'b00,
    S_DECODE = 2'b01,
    S_EXEC   = 2'b10,
    S_WB     = 2'b11
  } seqState_t;

  // True for the three operate opcodes this sequencer handles.
  function automatic logic isOperateOp(input logic [3:0] op);
    return (op == OP_ADD) || (op == OP_AND) || (op == OP_NOT);
  endfunction

  // Maps a legal operate opcode to its ALU control; anything else is PASS.
  function automatic aluCtrl_t opToAlu(input logic [3:0] op);
    case (op)
      OP_ADD:  return ALU_ADD;
      OP_AND:  return ALU_AND;
      OP_NOT:  return ALU_NOT;
      default: return ALU_PASS;
    endcase
  endfunction

endpackage

// File: rtl/lc3_nzp_gen.sv
// lc3_nzp_gen
//   Combinational condition-code generator. Exactly one of N/Z/P is set.
//   Shared by the operate path and the load path.
// Ports:
//   value  in  16  value being written to the register file
//   nzp    out  3  {N,Z,P}
module lc3_nzp_gen (
  input  logic [15:0] value,
  output logic [2:0]  nzp
);

  logic isNeg;
  logic isZero;

  assign isNeg  = value[15];
  assign isZero = (value == 16'h0000);
  assign nzp    = {isNeg, isZero, !isNeg && !isZero};

endmodule

// File: rtl/lc3_operate_seq.sv
// lc3_operate_seq
//   Sequencer for LC-3 ADD / AND / NOT. Accepts one instruction, drives the
//   register-file read addresses and ALU control, captures the ALU result,
//   writes it back and updates NZP. Four cycles per legal instruction, two
//   for a rejected one.
// Configuration macro:
//   LC3_STRICT_DECODE_EN  when defined, NOT with instr[5:0] != 6'h3F and
//                         ADD/AND register form with instr[4:3] != 00 are
//                         rejected as illegal. Undefined: those bits are
//                         ignored.
// Handshake: an instruction transfers on a rising edge where instr_valid and
//   instr_ready are both high. instr_ready is high only in IDLE; instr_valid
//   while busy is ignored (nothing is queued) and instr need only be stable
//   at the transfer edge.
// Ports:
//   clk, rst_n               clock, asynchronous active-low reset
//   instr_valid/instr/instr_ready  instruction handshake
//   sr1, sr2                 register-file read addresses (ALU Ra / Rb)
//   alu_control, alu_ir      ALU op and instr[5:0] forwarded to the ALU
//   alu_result               ALU output (combinational from sr1/sr2/alu_ir)
//   reg_we, reg_dr, reg_wdata  register-file write port
//   nzp                      condition codes {N,Z,P}
//   done, illegal            one-cycle retire / reject pulses
//   dbgState                 current sequencer state, for observation only
module lc3_operate_seq
  import lc3_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        instr_valid,
  input  logic [15:0] instr,
  output logic        instr_ready,
  output logic [2:0]  sr1,
  output logic [2:0]  sr2,
  output logic [1:0]  alu_control,
  output logic [5:0]  alu_ir,
  input  logic [15:0] alu_result,
  output logic        reg_we,
  output logic [2:0]  reg_dr,
  output logic [15:0] reg_wdata,
  output logic [2:0]  nzp,
  output logic        done,
  output logic        illegal,
  output logic [1:0]  dbgState
);

  seqState_t   state;
  aluCtrl_t    aluCtrlQ;
  logic [15:0] instrQ;
  logic [2:0]  nzpNext;
  logic        instrLegal;

  // Legality is judged on the incoming word at the accept edge so that the
  // registered illegal pulse lands in the DECODE cycle itself.
`ifdef LC3_STRICT_DECODE_EN
  always_comb begin
    instrLegal = isOperateOp(instr[15:12]);
    if (instr[15:12] == OP_NOT && instr[5:0] != 6'h3F)
      instrLegal = 1'b0;
    if ((instr[15:12] == OP_ADD || instr[15:12] == OP_AND) &&
        !instr[5] && instr[4:3] != 2'b00)
      instrLegal = 1'b0;
  end
`else
  assign instrLegal = isOperateOp(instr[15:12]);
`endif

  // NZP is computed from the ALU result as it is captured, so the new codes
  // are visible in the WB cycle together with reg_we.
  lc3_nzp_gen u_nzp_gen (
    .value (alu_result),
    .nzp   (nzpNext)
  );

  assign alu_control = aluCtrlQ;
  assign dbgState    = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      instrQ      <= 16'h0000;
      instr_ready <= 1'b1;
      sr1         <= 3'd0;
      sr2         <= 3'd0;
      reg_dr      <= 3'd0;
      aluCtrlQ    <= ALU_PASS;
      alu_ir      <= 6'd0;
      reg_wdata   <= 16'h0000;
      reg_we      <= 1'b0;
      done        <= 1'b0;
      illegal     <= 1'b0;
      nzp         <= 3'b010;
    end else begin
      case (state)
        S_IDLE: begin
          if (instr_valid && instr_ready) begin
            instrQ      <= instr;
            illegal     <= !instrLegal;
            instr_ready <= 1'b0;
            state       <= S_DECODE;
          end
        end
        S_DECODE: begin
          illegal <= 1'b0;
          if (illegal) begin
            // Rejected: registers and nzp stay as they were.
            instr_ready <= 1'b1;
            state       <= S_IDLE;
          end else begin
            sr1      <= instrQ[8:6];
            sr2      <= instrQ[2:0];
            reg_dr   <= instrQ[11:9];
            alu_ir   <= instrQ[5:0];
            aluCtrlQ <= opToAlu(instrQ[15:12]);
            state    <= S_EXEC;
          end
        end
        S_EXEC: begin
          reg_wdata <= alu_result;
          nzp       <= nzpNext;
          reg_we    <= 1'b1;
          done      <= 1'b1;
          state     <= S_WB;
        end
        S_WB: begin
          reg_we      <= 1'b0;
          done        <= 1'b0;
          aluCtrlQ    <= ALU_PASS;
          instr_ready <= 1'b1;
          state       <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
